// File: rtl/fifo_uart_pkg.sv
// Shared constants and FSM encoding for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } txState_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between an upstream FIFO (master) and the transmitter (slave).
interface fifo_uart_tx_if
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  sig_Empty;
    logic [DATA_WIDTH-1:0] buffer_Output;
    logic                  read_Enable;

    modport master (
        output sig_Empty,
        output buffer_Output,
        input  read_Enable
    );

    modport slave (
        input  sig_Empty,
        input  buffer_Output,
        output read_Enable
    );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: tick_o marks the last cycle of a bit, preTick_o the cycle before it.
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart_i,
    input  logic enable_i,
    output logic tick_o,
    output logic preTick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == LAST_CNT) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o    = enable_i && (count_q == LAST_CNT);
    assign preTick_o = enable_i && (count_q == PRE_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO and sends 8N1-style frames.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between data and stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           tx_Enable,
    fifo_uart_tx_if.slave  fifo,
    output logic           tx_Serial,
    output logic           tx_Busy,
    output logic           tx_Done
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    txState_t              state_q, state_d;
    logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
    logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic                  txSerial_q, txSerial_d;
    logic                  readEnable_q, readEnable_d;
    logic                  txBusy_q, txBusy_d;
    logic                  txDone_q, txDone_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic bitTick;
    logic bitPreTick;
    logic timerRun;

    assign timerRun = (state_q == START) || (state_q == DATA) ||
                      (state_q == PARITY) || (state_q == STOP);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clock     (clock),
        .reset     (reset),
        .restart_i (state_q == LOAD),
        .enable_i  (timerRun),
        .tick_o    (bitTick),
        .preTick_o (bitPreTick)
    );

    always_comb begin
        state_d    = state_q;
        bitIdx_d   = bitIdx_q;
        shiftReg_d = shiftReg_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_Enable && !fifo.sig_Empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shiftReg_d = fifo.buffer_Output;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d   = ^fifo.buffer_Output;
`endif
                state_d    = START;
            end
            START: begin
                if (bitTick) begin
                    bitIdx_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bitTick) begin
                    if (bitIdx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d   = bitIdx_q + 1'b1;
                        shiftReg_d = shiftReg_q >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bitTick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bitTick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so the registered copies line up with it.
        txSerial_d = 1'b1;
        case (state_d)
            START:   txSerial_d = 1'b0;
            DATA:    txSerial_d = shiftReg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  txSerial_d = parity_d;
`endif
            default: txSerial_d = 1'b1;
        endcase
        readEnable_d = (state_q == IDLE) && (state_d == FETCH);
        txBusy_d     = (state_d != IDLE);
        txDone_d     = (state_q == STOP) && bitPreTick;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bitIdx_q     <= '0;
            shiftReg_q   <= '0;
            txSerial_q   <= 1'b1;
            readEnable_q <= 1'b0;
            txBusy_q     <= 1'b0;
            txDone_q     <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bitIdx_q     <= bitIdx_d;
            shiftReg_q   <= shiftReg_d;
            txSerial_q   <= txSerial_d;
            readEnable_q <= readEnable_d;
            txBusy_q     <= txBusy_d;
            txDone_q     <= txDone_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign fifo.read_Enable = readEnable_q;
    assign tx_Serial        = txSerial_q;
    assign tx_Busy          = txBusy_q;
    assign tx_Done          = txDone_q;

endmodule
